wb_arbiter: RTL and testbench

- Shares the single result writeback bus between the memory unit and the ALUs of the out-of-order DLX core.
- Each functional unit hands over a completed result (issue-queue position, destination register, data). The block buffers one result per unit and grants the bus round-robin, one result per cycle.
- Results belonging to flushed issue-queue entries are discarded.
- Sits between the execution units and the finish/commit logic, which marks `finished` from the wb outputs.

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: one result buffer per functional unit,
// round-robin grant of one result per cycle, flushed entries dropped.
module wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IQ_SIZE    = 16,
  parameter int IQ_ADDR_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IQ_ADDR_W-1:0]  req_iqpos,
  input  logic [NUM_REQ-1:0]            req_use_rd,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic                          flush_valid,
  input  logic [IQ_SIZE-1:0]            flush_mask,
  output logic                          wb_valid,
  output logic [IQ_ADDR_W-1:0]          wb_iqpos,
  output logic                          wb_use_rd,
  output logic [REG_ADDR_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]             wb_data,
  output logic [NUM_REQ-1:0]            wb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                 full_q, full_d;
  logic [NUM_REQ-1:0][IQ_ADDR_W-1:0]  iqpos_q, iqpos_d;
  logic [NUM_REQ-1:0]                 use_rd_q, use_rd_d;
  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]     data_q, data_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [IQ_ADDR_W-1:0]  wb_iqpos_q, wb_iqpos_d;
  logic                  wb_use_rd_q, wb_use_rd_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [NUM_REQ-1:0]    wb_src_q, wb_src_d;

  logic [NUM_REQ-1:0] buf_kill;
  logic [NUM_REQ-1:0] in_kill;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;

  always_comb begin
    buf_kill = '0;
    in_kill  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_kill[i] = flush_valid & flush_mask[iqpos_q[i]];
      in_kill[i]  = flush_valid &
        flush_mask[req_iqpos[i*IQ_ADDR_W +: IQ_ADDR_W]];
      eligible[i] = full_q[i] & ~buf_kill[i];
    end
  end

  // Search starts at rr_ptr and wraps; first eligible wins.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_w;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!gnt_any && eligible[idx_w]) begin
        gnt_any       = 1'b1;
        gnt_idx       = idx_w;
        grant[idx_w]  = 1'b1;
      end
    end
  end

  assign req_ready = ~full_q | grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PTR_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else rr_ptr_d = gnt_idx + PTR_W'(1);
    end
  end

  // Grant and accept on the same unit reloads the buffer with no bubble.
  always_comb begin
    full_d   = full_q;
    iqpos_d  = iqpos_q;
    use_rd_d = use_rd_q;
    rd_d     = rd_q;
    data_d   = data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] | buf_kill[i]) full_d[i] = 1'b0;
      if (req_valid[i] & req_ready[i] & ~in_kill[i]) begin
        full_d[i]   = 1'b1;
        iqpos_d[i]  = req_iqpos[i*IQ_ADDR_W +: IQ_ADDR_W];
        use_rd_d[i] = req_use_rd[i];
        rd_d[i]     = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        data_d[i]   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    wb_valid_d  = gnt_any;
    wb_iqpos_d  = wb_iqpos_q;
    wb_use_rd_d = wb_use_rd_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_src_d    = wb_src_q;
    if (gnt_any) begin
      wb_iqpos_d  = iqpos_q[gnt_idx];
      wb_use_rd_d = use_rd_q[gnt_idx];
      wb_rd_d     = rd_q[gnt_idx];
      wb_data_d   = data_q[gnt_idx];
      wb_src_d    = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      iqpos_q     <= '0;
      use_rd_q    <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_iqpos_q  <= '0;
      wb_use_rd_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_src_q    <= '0;
    end else begin
      full_q      <= full_d;
      iqpos_q     <= iqpos_d;
      use_rd_q    <= use_rd_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_valid_q  <= wb_valid_d;
      wb_iqpos_q  <= wb_iqpos_d;
      wb_use_rd_q <= wb_use_rd_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_src_q    <= wb_src_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_iqpos  = wb_iqpos_q;
  assign wb_use_rd = wb_use_rd_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed steps then random traffic,
// compared against a per-unit slot model with round-robin selection.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_iqpos;
  logic [3:0]   req_use_rd;
  logic [19:0]  req_rd;
  logic [127:0] req_data;
  logic         flush_valid;
  logic [15:0]  flush_mask;
  logic         wb_valid;
  logic [3:0]   wb_iqpos;
  logic         wb_use_rd;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [3:0]   wb_src;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_iqpos(req_iqpos), .req_use_rd(req_use_rd),
    .req_rd(req_rd), .req_data(req_data),
    .flush_valid(flush_valid), .flush_mask(flush_mask),
    .wb_valid(wb_valid), .wb_iqpos(wb_iqpos),
    .wb_use_rd(wb_use_rd), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         v;
    logic [3:0] iq;
    logic       ur;
    logic [4:0] rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mb[4];
  int          rr;
  logic        e_valid;
  logic [3:0]  e_src;
  logic [41:0] e_fields;

  function automatic bit killed(logic [3:0] iq);
    return flush_valid && flush_mask[iq];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(int i, bit v, logic [3:0] iq, logic ur,
                       logic [4:0] rd, logic [31:0] d);
    req_valid[i]        = v;
    req_iqpos[i*4 +: 4] = iq;
    req_use_rd[i]       = ur;
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic idle();
    req_valid   = '0;
    flush_valid = 1'b0;
    flush_mask  = '0;
  endtask

  // One clock: predict ready and the winner, then check the bus.
  task automatic cycle();
    int g;
    int j;
    logic [3:0] er;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      j = (rr + k) % 4;
      if (g < 0 && mb[j].v && !killed(mb[j].iq)) g = j;
    end
    for (int i = 0; i < 4; i++) er[i] = !mb[i].v || g == i;
    #1;
    if (!rst) chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mb[i].v = 0;
      rr = 0;
      e_valid = 0;
      e_src = '0;
      e_fields = '0;
    end else begin
      if (g >= 0) begin
        e_valid  = 1;
        e_src    = 4'(1 << g);
        e_fields = {mb[g].iq, mb[g].ur, mb[g].rd, mb[g].d};
        rr       = (g + 1) % 4;
        mb[g].v  = 0;
      end else begin
        e_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (mb[i].v && killed(mb[i].iq)) mb[i].v = 0;
        if (req_valid[i] && er[i] && !killed(req_iqpos[i*4 +: 4])) begin
          mb[i].v  = 1;
          mb[i].iq = req_iqpos[i*4 +: 4];
          mb[i].ur = req_use_rd[i];
          mb[i].rd = req_rd[i*5 +: 5];
          mb[i].d  = req_data[i*32 +: 32];
        end
      end
    end
    #1;
    chk("wb_valid", 64'(wb_valid), 64'(e_valid));
    chk("wb_src", 64'(wb_src), 64'(e_src));
    chk("wb_fields", 64'({wb_iqpos, wb_use_rd, wb_rd, wb_data}),
        64'(e_fields));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mb[i].v = 0;
    rr = 0;
    e_valid = 0;
    e_src = '0;
    e_fields = '0;
    req_iqpos = '0;
    req_use_rd = '0;
    req_rd = '0;
    req_data = '0;
    idle();

    // Reset, then reset held with all units requesting.
    rst = 1;
    cycle();
    for (int i = 0; i < 4; i++) drive(i, 1, 4'(i), 1, 5'(i), 32'(i));
    cycle();
    chk("rst_hold_valid", 64'(wb_valid), 64'd0);
    rst = 0;
    idle();
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'hF);
    cycle();
    chk("idle_src", 64'(wb_src), 64'd0);

    // Single request on unit 2.
    drive(2, 1, 4'd5, 1, 5'd7, 32'hDEADBEEF);
    cycle();
    idle();
    cycle();
    chk("single_data", 64'(wb_data), 64'hDEADBEEF);
    chk("single_src", 64'(wb_src), 64'h4);
    chk("single_iq", 64'(wb_iqpos), 64'd5);
    chk("single_rd", 64'(wb_rd), 64'd7);
    cycle();
    chk("single_done", 64'(wb_valid), 64'd0);

    // Four simultaneous requests from a fresh rr pointer.
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++)
      drive(i, 1, 4'(i + 8), 1, 5'(i + 1), 32'h1000 + 32'(i));
    cycle();
    idle();
    cycle();
    chk("four_first", 64'(wb_src), 64'h1);
    cycle();
    cycle();
    cycle();
    chk("four_last", 64'(wb_src), 64'h8);
    cycle();

    // Units 0 and 1 streaming continuously.
    for (int n = 0; n < 10; n++) begin
      drive(0, 1, 4'($urandom), 1'($urandom), 5'($urandom), $urandom);
      drive(1, 1, 4'($urandom), 1'($urandom), 5'($urandom), $urandom);
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Flush drops unit 1 (iq 3) and the incoming unit 0 (iq 3).
    drive(1, 1, 4'd3, 1, 5'd11, 32'h11111111);
    drive(2, 1, 4'd9, 1, 5'd12, 32'h22222222);
    cycle();
    idle();
    flush_valid = 1;
    flush_mask  = 16'h0008;
    drive(0, 1, 4'd3, 1, 5'd13, 32'h33333333);
    cycle();
    chk("flush_iq", 64'(wb_iqpos), 64'd9);
    chk("flush_src", 64'(wb_src), 64'h4);
    idle();
    cycle();
    chk("flush_gone", 64'(wb_valid), 64'd0);
    cycle();

    // Reset with three buffers full.
    for (int i = 0; i < 3; i++)
      drive(i, 1, 4'(i), 0, 5'(i), 32'hA0 + 32'(i));
    cycle();
    idle();
    rst = 1;
    cycle();
    chk("midrst_valid", 64'(wb_valid), 64'd0);
    rst = 0;
    drive(3, 1, 4'd14, 1, 5'd30, 32'hCAFEF00D);
    cycle();
    idle();
    cycle();
    chk("midrst_src", 64'(wb_src), 64'h8);
    cycle();

    // Random traffic with flushes and occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 4; i++)
        drive(i, 1'($urandom), 4'($urandom), 1'($urandom),
              5'($urandom), $urandom);
      flush_valid = ($urandom_range(0, 3) == 0);
      flush_mask  = 16'($urandom);
      cycle();
    end
    rst = 0;
    idle();
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
